// File: rtl/bus_control_sequencer.sv
// rtl/bus_control_sequencer.sv - fetch/decode/interrupt sequencer for the Basic Computer
//
// Purpose:
//   Steps through the T0-T2 fetch/decode cycle and the RT0-RT2 interrupt cycle.
//   Drives the 3-bit common-bus select and the register/memory micro-op strobes.
//   Hands each decoded instruction to the execute unit with a start/done handshake.
//   Bus source map: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM.
//
// Ports:
//   clk, rst          system clock; synchronous active-high reset
//   ir_in             current IR contents (opcode = [IR_W-2:IR_W-4], I bit = MSB)
//   exec_done         execute unit finished the instruction (sampled only in EXEC)
//   halt_req          HLT executed (sampled only in EXEC)
//   ien_set, ien_clr  ION / IOF micro-ops
//   fgi, fgo          input/output flags
//   bus_sel           common bus select
//   ar_load ... mem_write  Moore micro-op strobes
//   exec_start        one-cycle pulse on the first EXEC cycle
//   d_op, i_bit       registered opcode decode and indirect bit
//   ien, r_flag       interrupt-enable and interrupt-cycle flip-flops
//   halted            high while in HALT
module bus_control_sequencer #(
    parameter int IR_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IR_W-1:0] ir_in,
    input  logic            exec_done,
    input  logic            halt_req,
    input  logic            ien_set,
    input  logic            ien_clr,
    input  logic            fgi,
    input  logic            fgo,
    output logic [2:0]      bus_sel,
    output logic            ar_load,
    output logic            ar_clr,
    output logic            pc_inc,
    output logic            pc_clr,
    output logic            ir_load,
    output logic            tr_load,
    output logic            mem_read,
    output logic            mem_write,
    output logic            exec_start,
    output logic [7:0]      d_op,
    output logic            i_bit,
    output logic            ien,
    output logic            r_flag,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_F0   = 3'd0,
        S_F1   = 3'd1,
        S_F2   = 3'd2,
        S_EXEC = 3'd3,
        S_INT0 = 3'd4,
        S_INT1 = 3'd5,
        S_INT2 = 3'd6,
        S_HALT = 3'd7
    } state_t;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_TR   = 3'd6;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    state_t     state_q, state_d;
    logic [7:0] d_op_q, d_op_d;
    logic       i_bit_q, i_bit_d;
    logic       ien_q, ien_d;
    logic       r_flag_q, r_flag_d;
    logic       exec_start_q, exec_start_d;
    logic       int_cond;

    // Only the opcode and I bit of the IR matter here; the address field is ignored.
    logic unused_ir_addr;
    assign unused_ir_addr = ^ir_in[IR_W-5:0];

    // Interrupt request seen in EXEC this cycle, using the registered enable.
    assign int_cond = (state_q == S_EXEC) && ien_q && (fgi || fgo);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_F0;
            d_op_q       <= 8'd0;
            i_bit_q      <= 1'b0;
            ien_q        <= 1'b0;
            r_flag_q     <= 1'b0;
            exec_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            d_op_q       <= d_op_d;
            i_bit_q      <= i_bit_d;
            ien_q        <= ien_d;
            r_flag_q     <= r_flag_d;
            exec_start_q <= exec_start_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        d_op_d       = d_op_q;
        i_bit_d      = i_bit_q;
        r_flag_d     = r_flag_q | int_cond;
        exec_start_d = 1'b0;
        bus_sel      = BUS_NONE;
        ar_load      = 1'b0;
        ar_clr       = 1'b0;
        pc_inc       = 1'b0;
        pc_clr       = 1'b0;
        ir_load      = 1'b0;
        tr_load      = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        halted       = 1'b0;

        // Clear wins over set; the INT2 clear below wins over both.
        ien_d = ien_q;
        if (ien_set) ien_d = 1'b1;
        if (ien_clr) ien_d = 1'b0;

        unique case (state_q)
            S_F0: begin
                bus_sel = BUS_PC;
                ar_load = 1'b1;
                state_d = S_F1;
            end
            S_F1: begin
                bus_sel  = BUS_MEM;
                mem_read = 1'b1;
                ir_load  = 1'b1;
                pc_inc   = 1'b1;
                state_d  = S_F2;
            end
            S_F2: begin
                bus_sel      = BUS_IR;
                ar_load      = 1'b1;
                d_op_d       = 8'd1 << ir_in[IR_W-2:IR_W-4];
                i_bit_d      = ir_in[IR_W-1];
                exec_start_d = 1'b1;
                state_d      = S_EXEC;
            end
            S_EXEC: begin
                if (halt_req) begin
                    state_d = S_HALT;
                end else if (exec_done) begin
                    state_d = (r_flag_q || int_cond) ? S_INT0 : S_F0;
                end
            end
            S_INT0: begin
                ar_clr  = 1'b1;
                bus_sel = BUS_PC;
                tr_load = 1'b1;
                state_d = S_INT1;
            end
            S_INT1: begin
                bus_sel   = BUS_TR;
                mem_write = 1'b1;
                pc_clr    = 1'b1;
                state_d   = S_INT2;
            end
            S_INT2: begin
                pc_inc   = 1'b1;
                ien_d    = 1'b0;
                r_flag_d = 1'b0;
                state_d  = S_F0;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_F0;
            end
        endcase
    end

    assign exec_start = exec_start_q;
    assign d_op       = d_op_q;
    assign i_bit      = i_bit_q;
    assign ien        = ien_q;
    assign r_flag     = r_flag_q;

endmodule
